// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back register file: MemtoReg select encodings
// and default datapath/index widths.
package wb_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC  = 2'b10,
    MTR_RSV = 2'b11
  } mtr_e;

endpackage

// File: rtl/wb_mux.sv
// Write-back data select: ALU result, load data or link address.
// The reserved encoding falls back to the ALU result.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [1:0]        i_sel,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_alu;
    case (mtr_e'(i_sel))
      MTR_MEM: o_data = i_mem;
      MTR_PC:  o_data = i_pc;
      default: o_data = i_alu;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Register file with write-back select, two combinational read ports and a retire counter.
// Define WB_REGFILE_BYPASS_EN to forward the committing write to same-cycle reads.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] ReadDataIn,
  input  logic [DATA_W-1:0] PCResultIn,
  input  logic [1:0]        MemtoRegIn,
  input  logic              RegWriteIn,
  input  logic [ADDR_W-1:0] WriteRegIn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [31:0]       RetireCount
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [31:0]       r_retire_cnt;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .i_alu  (ALUResultIn),
    .i_mem  (ReadDataIn),
    .i_pc   (PCResultIn),
    .i_sel  (MemtoRegIn),
    .o_data (w_wdata)
  );

  // Qualifying with Reset keeps the bypass path quiet while the file is held in reset.
  assign w_we = RegWriteIn && (WriteRegIn != '0) && Reset;

  // Entry 0 is only ever cleared, so it reads as zero without a special read case.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
      r_retire_cnt <= '0;
    end else if (w_we) begin
      r_regs[WriteRegIn] <= w_wdata;
      r_retire_cnt       <= r_retire_cnt + 32'd1;
    end
  end

  always_comb begin
    w_rd1 = r_regs[ReadReg1];
    w_rd2 = r_regs[ReadReg2];
`ifdef WB_REGFILE_BYPASS_EN
    if (w_we && (ReadReg1 == WriteRegIn)) begin
      w_rd1 = w_wdata;
    end
    if (w_we && (ReadReg2 == WriteRegIn)) begin
      w_rd2 = w_wdata;
    end
`else
    w_rd1 = r_regs[ReadReg1];
    w_rd2 = r_regs[ReadReg2];
`endif
  end

  assign ReadData1    = w_rd1;
  assign ReadData2    = w_rd2;
  assign WriteDataOut = w_wdata;
  assign RetireCount  = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised scoreboard bench for wb_regfile; expectations come from an array-based model
// and are checked by a separate monitor on the falling clock edge.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_in;
  logic [31:0] mem_in;
  logic [31:0] pc_in;
  logic [1:0]  mtr;
  logic        we;
  logic [4:0]  wa;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wdo;
  logic [31:0] cnt;

  wb_regfile dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .ALUResultIn  (alu_in),
    .ReadDataIn   (mem_in),
    .PCResultIn   (pc_in),
    .MemtoRegIn   (mtr),
    .RegWriteIn   (we),
    .WriteRegIn   (wa),
    .ReadReg1     (ra1),
    .ReadReg2     (ra2),
    .ReadData1    (rd1),
    .ReadData2    (rd2),
    .WriteDataOut (wdo),
    .RetireCount  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          which;   // 0 rd1, 1 rd2, 2 write data, 3 retire count
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  bit          m_rst_n;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] m_wdata(logic [1:0] s, logic [31:0] a, logic [31:0] m,
                                          logic [31:0] p);
    if (s == 2'd1) return m;
    if (s == 2'd2) return p;
    return a;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] idx, bit w, logic [4:0] waddr,
                                         logic [31:0] wd);
    if (!m_rst_n) return 32'd0;
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && w && (waddr != 5'd0) && (idx == waddr)) return wd;
    return m_regs[idx];
  endfunction

  // Monitor: every falling edge, compare whatever the stimulus side has queued.
  always @(negedge clk) begin
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      case (e.which)
        0:       act = rd1;
        1:       act = rd2;
        2:       act = wdo;
        default: act = cnt;
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  // Called just after a rising edge: apply inputs, queue expectations, advance the model.
  task automatic drive(input logic [1:0] s, input logic [31:0] a, input logic [31:0] m,
                       input logic [31:0] p, input bit w, input logic [4:0] waddr,
                       input logic [4:0] r1, input logic [4:0] r2, input string tag);
    logic [31:0] wd;
    wd     = m_wdata(s, a, m, p);
    mtr    = s;
    alu_in = a;
    mem_in = m;
    pc_in  = p;
    we     = w;
    wa     = waddr;
    ra1    = r1;
    ra2    = r2;
    sb_q.push_back('{name: {tag, ".rd1"}, which: 0, exp: m_read(r1, w, waddr, wd)});
    sb_q.push_back('{name: {tag, ".rd2"}, which: 1, exp: m_read(r2, w, waddr, wd)});
    sb_q.push_back('{name: {tag, ".wdata"}, which: 2, exp: wd});
    sb_q.push_back('{name: {tag, ".count"}, which: 3, exp: m_cnt});
    @(posedge clk);
    if (m_rst_n && w && (waddr != 5'd0)) begin
      m_regs[waddr] = wd;
      m_cnt         = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2, input string tag);
    drive(2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, r1, r2, tag);
  endtask

  task automatic model_reset();
    m_rst_n = 1'b0;
    m_cnt   = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  initial begin
    rst_n  = 1'b0;
    alu_in = '0;
    mem_in = '0;
    pc_in  = '0;
    mtr    = '0;
    we     = 1'b0;
    wa     = '0;
    ra1    = '0;
    ra2    = '0;
    model_reset();
    @(posedge clk);
    #1;
    idle(5'd1, 5'd31, "reset_state");
    rst_n   = 1'b1;
    m_rst_n = 1'b1;
    idle(5'd2, 5'd3, "after_reset");

    // Write-data select, landing in r3
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 32'hA, 32'hB, 32'hC, 1'b1, 5'd3, 5'd3, 5'd0, $sformatf("mtr%0d", s));
      idle(5'd3, 5'd3, $sformatf("mtr%0d_r3", s));
    end

    // Writes to r0 are discarded and do not retire
    drive(2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, "r0_write");
    idle(5'd0, 5'd0, "r0_read");
    n_cmp++;
    if (rd1 !== 32'd0) begin
      n_bad++;
      $display("FAIL r0_direct: got %h expected %h", rd1, 32'd0);
    end
    n_cmp++;
    if (cnt !== m_cnt) begin
      n_bad++;
      $display("FAIL r0_count_direct: got %h expected %h", cnt, m_cnt);
    end

    // Same-cycle read of a register being written
    drive(2'd1, 32'd0, 32'h11, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, "r7_pre");
    drive(2'd0, 32'h55, 32'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd1, "r7_bypass");
    idle(5'd7, 5'd7, "r7_next");

    // Both ports on the same index
    drive(2'd2, 32'd0, 32'd0, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0, "r9_write");
    idle(5'd9, 5'd9, "r9_dual");
    n_cmp++;
    if (rd1 !== 32'h99) begin
      n_bad++;
      $display("FAIL r9_rd1_direct: got %h expected %h", rd1, 32'h99);
    end
    n_cmp++;
    if (rd2 !== 32'h99) begin
      n_bad++;
      $display("FAIL r9_rd2_direct: got %h expected %h", rd2, 32'h99);
    end

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      logic [4:0] waddr;
      logic [4:0] r1;
      waddr = 5'($urandom_range(0, 31));
      r1    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
            waddr, r1, 5'($urandom_range(0, 31)), $sformatf("rand%0d", n));
    end

    // Mid-run asynchronous reset, with a write attempted while it is held
    drive(2'd0, 32'h77, 32'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0, "r5_prefill");
    rst_n = 1'b0;
    model_reset();
    drive(2'd0, 32'h1234, 32'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd3, "rst_write_r5");
    idle(5'd5, 5'd9, "rst_held");
    n_cmp++;
    if (rd1 !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_r5_direct: got %h expected %h", rd1, 32'd0);
    end
    n_cmp++;
    if (cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_count_direct: got %h expected %h", cnt, 32'd0);
    end
    rst_n   = 1'b1;
    m_rst_n = 1'b1;
    idle(5'd5, 5'd7, "rst_release");

    // Counter wrap from a preset value
    force dut.r_retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      drive(2'd0, 32'(k + 1), 32'd0, 32'd0, 1'b1, 5'd10, 5'd10, 5'd0, $sformatf("wrap%0d", k));
    end
    idle(5'd10, 5'd0, "wrap_end");
    n_cmp++;
    if (cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL wrap_direct: got %h expected %h", cnt, 32'd1);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
